// File: rtl/alarm_trigger.sv
// alarm_trigger: compares the running time against three alarm times and
// runs the ring / snooze sequence that drives the buzzer and status LEDs.
//
// Strobe semantics: tick_1hz, stop_pulse and snooze_pulse are single-cycle
// strobes. Each one is acted on at the clk edge that samples it high. There is
// no backpressure: a strobe that arrives while the current state ignores it is
// simply dropped.
module alarm_trigger #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_1hz,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_minute,
  input  logic [7:0]  cur_second,
  input  logic [23:0] alarm1_time,
  input  logic [23:0] alarm2_time,
  input  logic [23:0] alarm3_time,
  input  logic [2:0]  alarm_en,
  input  logic        edit_active,
  input  logic        stop_pulse,
  input  logic        snooze_pulse,
  output logic        ringing,
  output logic        snoozing,
  output logic [1:0]  ring_id,
  output logic        buzzer,
  output logic [1:0]  snooze_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  localparam logic [7:0] RING_LOAD   = 8'(RING_SECONDS);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECONDS);
  localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

  state_t      state_q, state_d;
  logic [2:0]  match, match_q, rise, rise_other, id_mask;
  logic [1:0]  ring_id_q, ring_id_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic [9:0]  snooze_cnt_q, snooze_cnt_d;
  logic        beep_q, beep_d;
  logic [1:0]  snooze_count_q, snooze_count_d;
  logic [1:0]  rise_sel, other_sel;
  logic        cur_en;
  logic [23:0] cur_time;

  // Fixed priority: alarm1 beats alarm2 beats alarm3; 0 means none.
  function automatic logic [1:0] pick_first(input logic [2:0] r);
    if (r[0])      return 2'd1;
    else if (r[1]) return 2'd2;
    else if (r[2]) return 2'd3;
    else           return 2'd0;
  endfunction

  assign cur_time = {cur_hour, cur_minute, cur_second};

  // Per-alarm match and its rising edge; only a fresh match can trigger.
  always_comb begin
    match[0]   = alarm_en[0] & (alarm1_time == cur_time);
    match[1]   = alarm_en[1] & (alarm2_time == cur_time);
    match[2]   = alarm_en[2] & (alarm3_time == cur_time);
    rise       = match & ~match_q;
    rise_other = rise & ~id_mask;
    rise_sel   = pick_first(rise);
    other_sel  = pick_first(rise_other);
  end

  // Decode the active alarm into a one-hot mask and its enable bit.
  always_comb begin
    id_mask = 3'b000;
    cur_en  = 1'b0;
    case (ring_id_q)
      2'd1:    begin id_mask = 3'b001; cur_en = alarm_en[0]; end
      2'd2:    begin id_mask = 3'b010; cur_en = alarm_en[1]; end
      2'd3:    begin id_mask = 3'b100; cur_en = alarm_en[2]; end
      default: begin id_mask = 3'b000; cur_en = 1'b0;        end
    endcase
  end

  // Match history; reset to all-ones so a time already matching at reset is
  // not treated as a new match.
  always_ff @(posedge clk) begin
    if (!reset_n) match_q <= 3'b111;
    else          match_q <= match;
  end

  // Next-state logic. Within RING/SNOOZE the if-chain order sets priority:
  // stop, enable drop, snooze, then tick expiry.
  always_comb begin
    state_d        = state_q;
    ring_id_d      = ring_id_q;
    ring_cnt_d     = ring_cnt_q;
    snooze_cnt_d   = snooze_cnt_q;
    beep_d         = beep_q;
    snooze_count_d = snooze_count_q;
    case (state_q)
      S_IDLE: begin
        if ((rise_sel != 2'd0) && !edit_active) begin
          state_d        = S_RING;
          ring_id_d      = rise_sel;
          ring_cnt_d     = RING_LOAD;
          beep_d         = 1'b1;
          snooze_count_d = 2'd0;
        end
      end
      S_RING: begin
        if (stop_pulse || !cur_en) begin
          state_d        = S_IDLE;
          ring_id_d      = 2'd0;
          snooze_count_d = 2'd0;
          beep_d         = 1'b0;
        end else if (snooze_pulse) begin
          if (snooze_count_q == SNOOZE_MAX) begin
            state_d        = S_IDLE;
            ring_id_d      = 2'd0;
            snooze_count_d = 2'd0;
            beep_d         = 1'b0;
          end else begin
            state_d        = S_SNOOZE;
            snooze_cnt_d   = SNOOZE_LOAD;
            snooze_count_d = snooze_count_q + 2'd1;
          end
        end else if (tick_1hz) begin
          if (ring_cnt_q == 8'd1) begin
            state_d        = S_IDLE;
            ring_id_d      = 2'd0;
            snooze_count_d = 2'd0;
            beep_d         = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q - 8'd1;
            beep_d     = ~beep_q;
          end
        end
      end
      S_SNOOZE: begin
        if (stop_pulse || !cur_en) begin
          state_d        = S_IDLE;
          ring_id_d      = 2'd0;
          snooze_count_d = 2'd0;
          beep_d         = 1'b0;
        end else if ((other_sel != 2'd0) && !edit_active) begin
          // A different alarm takes over as a brand-new event.
          state_d        = S_RING;
          ring_id_d      = other_sel;
          ring_cnt_d     = RING_LOAD;
          beep_d         = 1'b1;
          snooze_count_d = 2'd0;
        end else if (tick_1hz) begin
          if (snooze_cnt_q == 10'd1) begin
            state_d    = S_RING;
            ring_cnt_d = RING_LOAD;
            beep_d     = 1'b1;
          end else begin
            snooze_cnt_d = snooze_cnt_q - 10'd1;
          end
        end
      end
      default: begin
        state_d        = S_IDLE;
        ring_id_d      = 2'd0;
        snooze_count_d = 2'd0;
        beep_d         = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      ring_id_q      <= 2'd0;
      ring_cnt_q     <= 8'd0;
      snooze_cnt_q   <= 10'd0;
      beep_q         <= 1'b0;
      snooze_count_q <= 2'd0;
    end else begin
      state_q        <= state_d;
      ring_id_q      <= ring_id_d;
      ring_cnt_q     <= ring_cnt_d;
      snooze_cnt_q   <= snooze_cnt_d;
      beep_q         <= beep_d;
      snooze_count_q <= snooze_count_d;
    end
  end

  assign ringing      = (state_q == S_RING);
  assign snoozing     = (state_q == S_SNOOZE);
  assign ring_id      = ring_id_q;
  assign buzzer       = ringing & beep_q;
  assign snooze_count = snooze_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: directed scenarios plus randomized traffic, with
// every cycle compared against a seconds-counting reference model.
module tb_alarm_trigger;

  localparam int RING_S = 60;
  localparam int SNZ_S  = 300;
  localparam int MAX_S  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, tick_1hz, edit_active, stop_pulse, snooze_pulse;
  logic [23:0] cur_time, alarm1_time, alarm2_time, alarm3_time;
  logic [2:0]  alarm_en;
  logic        ringing, snoozing, buzzer;
  logic [1:0]  ring_id, snooze_count, state_dbg;

  alarm_trigger #(.RING_SECONDS(RING_S), .SNOOZE_SECONDS(SNZ_S), .MAX_SNOOZE(MAX_S)) dut (
    .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz),
    .cur_hour(cur_time[23:16]), .cur_minute(cur_time[15:8]), .cur_second(cur_time[7:0]),
    .alarm1_time(alarm1_time), .alarm2_time(alarm2_time), .alarm3_time(alarm3_time),
    .alarm_en(alarm_en), .edit_active(edit_active),
    .stop_pulse(stop_pulse), .snooze_pulse(snooze_pulse),
    .ringing(ringing), .snoozing(snoozing), .ring_id(ring_id), .buzzer(buzzer),
    .snooze_count(snooze_count), .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd8(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [23:0] bcd24(input int s);
    return {bcd8(s / 3600), bcd8((s / 60) % 60), bcd8(s % 60)};
  endfunction

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 ringing, 2 snoozing. Ring and snooze progress is tracked
  // as seconds elapsed since entry; beep is on for even elapsed seconds.
  int       m_mode, m_id, m_snz, m_ring_ticks, m_snz_ticks;
  bit [2:0] m_prev;

  function automatic logic [23:0] alarm_time(input int i);
    if (i == 0) return alarm1_time;
    if (i == 1) return alarm2_time;
    return alarm3_time;
  endfunction

  task automatic start_ring(input int id, input int snz);
    m_mode = 1; m_id = id; m_snz = snz; m_ring_ticks = 0;
  endtask

  always @(posedge clk) begin : model
    bit [2:0] now_m;
    int fresh, other;
    if (!reset_n) begin
      m_mode = 0; m_id = 0; m_snz = 0; m_ring_ticks = 0; m_snz_ticks = 0;
      m_prev = 3'b111;
    end else begin
      for (int i = 0; i < 3; i++) now_m[i] = alarm_en[i] && (alarm_time(i) == cur_time);
      fresh = 0; other = 0;
      for (int i = 2; i >= 0; i--) begin
        if (now_m[i] && !m_prev[i]) begin
          fresh = i + 1;
          if (i + 1 != m_id) other = i + 1;
        end
      end
      case (m_mode)
        0: if (fresh != 0 && !edit_active) start_ring(fresh, 0);
        1: begin
          if (stop_pulse || !alarm_en[m_id-1]) m_mode = 0;
          else if (snooze_pulse) begin
            if (m_snz >= MAX_S) m_mode = 0;
            else begin m_mode = 2; m_snz++; m_snz_ticks = 0; end
          end else if (tick_1hz) begin
            m_ring_ticks++;
            if (m_ring_ticks == RING_S) m_mode = 0;
          end
        end
        default: begin
          if (stop_pulse || !alarm_en[m_id-1]) m_mode = 0;
          else if (other != 0 && !edit_active) start_ring(other, 0);
          else if (tick_1hz) begin
            m_snz_ticks++;
            if (m_snz_ticks == SNZ_S) start_ring(m_id, m_snz);
          end
        end
      endcase
      m_prev = now_m;
    end
  end

  // Scoreboard: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check_val("ringing",      32'(ringing),      32'(m_mode == 1));
      check_val("snoozing",     32'(snoozing),     32'(m_mode == 2));
      check_val("ring_id",      32'(ring_id),      (m_mode == 0) ? 32'd0 : 32'(m_id));
      check_val("buzzer",       32'(buzzer),       32'((m_mode == 1) && (m_ring_ticks % 2 == 0)));
      check_val("snooze_count", 32'(snooze_count), (m_mode == 0) ? 32'd0 : 32'(m_snz));
    end
  end

  // ---------------- driver tasks ----------------
  int t_now;

  task automatic sec_to(input int s);
    @(negedge clk);
    t_now = s; cur_time = bcd24(s); tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  task automatic sec_step();
    sec_to((t_now + 1) % 86400);
  endtask

  task automatic pulse(input bit s, input bit z);
    @(negedge clk);
    stop_pulse = s; snooze_pulse = z;
    @(negedge clk);
    stop_pulse = 1'b0; snooze_pulse = 1'b0;
  endtask

  task automatic arm(input int s1, input int s2, input int s3, input logic [2:0] en);
    @(negedge clk);
    alarm1_time = bcd24(s1); alarm2_time = bcd24(s2); alarm3_time = bcd24(s3);
    alarm_en = en;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; tick_1hz = 1'b0; edit_active = 1'b0;
    stop_pulse = 1'b0; snooze_pulse = 1'b0;
    t_now = hms(7, 0, 0); cur_time = bcd24(t_now);
    alarm1_time = 24'h0; alarm2_time = 24'h0; alarm3_time = 24'h0; alarm_en = 3'b000;
    repeat (2) @(negedge clk);
    check_val("rst_ringing", 32'(ringing), 32'd0);
    check_val("rst_ring_id", 32'(ring_id), 32'd0);
    check_val("rst_buzzer",  32'(buzzer),  32'd0);
    reset_n = 1'b1;

    // Basic ring with beep pattern and timeout.
    arm(hms(7, 30, 0), hms(1, 0, 0), hms(2, 0, 0), 3'b001);
    sec_to(hms(7, 29, 59));
    sec_step();
    check_val("t1_ringing", 32'(ringing), 32'd1);
    check_val("t1_ring_id", 32'(ring_id), 32'd1);
    check_val("t1_buzzer",  32'(buzzer),  32'd1);
    for (int k = 1; k <= RING_S; k++) begin
      sec_step();
      if (k < RING_S) check_val("t1_beep", 32'(buzzer), 32'(k % 2 == 0));
      else            check_val("t1_timeout", 32'(ringing), 32'd0);
    end

    // Simultaneous alarm1/alarm3: alarm1 wins, alarm3 is dropped.
    arm(hms(6, 0, 0), hms(1, 0, 0), hms(6, 0, 0), 3'b101);
    sec_to(hms(5, 59, 59));
    sec_step();
    check_val("t2_ring_id", 32'(ring_id), 32'd1);
    pulse(1'b1, 1'b0);
    check_val("t2_stop", 32'(ringing), 32'd0);
    repeat (3) sec_step();
    check_val("t2_no_alarm3", 32'(ringing), 32'd0);

    // Snooze cycle up to the limit.
    arm(hms(8, 0, 0), hms(1, 0, 0), hms(2, 0, 0), 3'b001);
    sec_to(hms(7, 59, 59));
    sec_step();
    for (int r = 1; r <= MAX_S; r++) begin
      pulse(1'b0, 1'b1);
      check_val("t3_snoozing", 32'(snoozing), 32'd1);
      check_val("t3_count", 32'(snooze_count), 32'(r));
      for (int k = 1; k <= SNZ_S; k++) sec_step();
      check_val("t3_rering", 32'(ringing), 32'd1);
    end
    pulse(1'b0, 1'b1);
    check_val("t3_limit_ring", 32'(ringing), 32'd0);
    check_val("t3_limit_snz",  32'(snoozing), 32'd0);

    // Stop and snooze together; then a match during edit mode.
    arm(hms(11, 0, 0), hms(1, 0, 0), hms(2, 0, 0), 3'b001);
    sec_to(hms(10, 59, 59));
    sec_step();
    pulse(1'b1, 1'b1);
    check_val("t4_stop_wins", 32'(ringing | snoozing), 32'd0);
    check_val("t4_count",     32'(snooze_count), 32'd0);
    arm(hms(11, 5, 0), hms(1, 0, 0), hms(2, 0, 0), 3'b001);
    edit_active = 1'b1;
    sec_to(hms(11, 4, 59));
    sec_step();
    check_val("t4_edit_block", 32'(ringing), 32'd0);
    edit_active = 1'b0;
    sec_step();
    check_val("t4_edit_after", 32'(ringing), 32'd0);

    // Pre-emption during snooze, then enable drop.
    arm(hms(9, 0, 0), hms(9, 0, 5), hms(2, 0, 0), 3'b011);
    sec_to(hms(8, 59, 59));
    sec_step();
    pulse(1'b0, 1'b1);
    repeat (5) sec_step();
    check_val("t5_preempt_id",  32'(ring_id), 32'd2);
    check_val("t5_preempt_cnt", 32'(snooze_count), 32'd0);
    @(negedge clk);
    alarm_en = 3'b001;
    @(negedge clk);
    check_val("t5_en_drop", 32'(ringing), 32'd0);

    // Reset while ringing with the time still matching.
    arm(hms(10, 0, 0), hms(1, 0, 0), hms(2, 0, 0), 3'b001);
    sec_to(hms(9, 59, 59));
    sec_step();
    check_val("t6_ringing", 32'(ringing), 32'd1);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    check_val("t6_rst_ring", 32'(ringing), 32'd0);
    check_val("t6_rst_id",   32'(ring_id), 32'd0);
    repeat (3) @(negedge clk);
    check_val("t6_no_retrig", 32'(ringing), 32'd0);
    sec_to(hms(9, 59, 59));
    sec_step();
    check_val("t6_refire", 32'(ring_id), 32'd1);
    pulse(1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      int b;
      @(negedge clk);
      if (i % 100 == 0) begin
        alarm1_time = bcd24((t_now + $urandom_range(1, 40)) % 86400);
        alarm2_time = ($urandom_range(0, 3) == 0) ? alarm1_time
                                                  : bcd24((t_now + $urandom_range(1, 40)) % 86400);
        alarm3_time = bcd24((t_now + $urandom_range(1, 40)) % 86400);
        alarm_en    = 3'($urandom_range(0, 7));
      end
      stop_pulse   = ($urandom_range(0, 99) < 1);
      snooze_pulse = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) edit_active = ~edit_active;
      if ($urandom_range(0, 299) == 0) begin
        b = $urandom_range(0, 2);
        alarm_en[b] = ~alarm_en[b];
      end
      if ($urandom_range(0, 1) == 1) begin
        t_now = (t_now + 1) % 86400; cur_time = bcd24(t_now); tick_1hz = 1'b1;
      end else begin
        tick_1hz = 1'b0;
      end
    end
    @(negedge clk);
    stop_pulse = 1'b0; snooze_pulse = 1'b0; tick_1hz = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
